// File: rtl/jtbubl_pkg.sv
// Shared definitions for the shared work-RAM arbiter: sequencer states and
// requester indices.
package jtbubl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } shram_st_t;

  localparam logic MAIN = 1'b0;
  localparam logic SUB  = 1'b1;

endpackage

// File: rtl/jtbubl_shram_port.sv
// Per-requester state for the shared RAM arbiter: served flag, read data
// latch, wait line and pending request.
module jtbubl_shram_port #(
  parameter int DW = 8
) (
  input  logic          clk24,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          en,
  input  logic          done,
  input  logic          rd,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] dout,
  output logic          wait_n,
  output logic          pending
);

  logic served;

  assign pending = cs & en & ~served;
  assign wait_n  = ~pending;

  // A dropped cs always clears served, so an aborted access never counts.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      served <= 1'b0;
      dout   <= '0;
    end else begin
      if (!cs)
        served <= 1'b0;
      else if (done)
        served <= 1'b1;
      if (done && rd)
        dout <= ram_q;
    end
  end

endmodule

// File: rtl/jtbubl_shram_arb.sv
// Main/sub Z80 arbiter for the single-port shared work RAM.
// Define JTBUBL_SHRAM_RR_EN for round-robin ties; default is main priority.
module jtbubl_shram_arb
  import jtbubl_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk24,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_wait_n,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_wait_n,
  input  logic          sub_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  shram_st_t st;
  logic      gnt, last_grant, rd, pick;
  logic      main_pend, sub_pend, main_done, sub_done;

  assign main_done = (st == CAPTURE) && (gnt == MAIN);
  assign sub_done  = (st == CAPTURE) && (gnt == SUB);

  always_comb begin
    pick = MAIN;
    if (main_pend && sub_pend) begin
`ifdef JTBUBL_SHRAM_RR_EN
      pick = (last_grant == SUB) ? MAIN : SUB;
`else
      pick = MAIN;
`endif
    end else if (!main_pend) begin
      pick = SUB;
    end
  end

  // The granted request is loaded straight into the RAM port registers, so
  // they are already valid during ISSUE; ram_we self-clears after one cycle.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      gnt        <= MAIN;
      last_grant <= SUB;
      rd         <= 1'b1;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      ram_we <= 1'b0;
      case (st)
        IDLE: begin
          if (main_pend || sub_pend) begin
            gnt <= pick;
            st  <= ISSUE;
            if (pick == MAIN) begin
              ram_addr <= main_addr;
              ram_din  <= main_din;
              ram_we   <= main_we;
              rd       <= ~main_we;
            end else begin
              ram_addr <= sub_addr;
              ram_din  <= sub_din;
              ram_we   <= sub_we;
              rd       <= ~sub_we;
            end
          end
        end
        ISSUE:   st <= CAPTURE;
        CAPTURE: begin
          last_grant <= gnt;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  jtbubl_shram_port #(.DW(DW)) u_main (
    .clk24   (clk24),
    .rst_n   (rst_n),
    .cs      (main_cs),
    .en      (1'b1),
    .done    (main_done),
    .rd      (rd),
    .ram_q   (ram_q),
    .dout    (main_dout),
    .wait_n  (main_wait_n),
    .pending (main_pend)
  );

  jtbubl_shram_port #(.DW(DW)) u_sub (
    .clk24   (clk24),
    .rst_n   (rst_n),
    .cs      (sub_cs),
    .en      (sub_en),
    .done    (sub_done),
    .rd      (rd),
    .ram_q   (ram_q),
    .dout    (sub_dout),
    .wait_n  (sub_wait_n),
    .pending (sub_pend)
  );

endmodule
